soc_mem_arbiter: RTL and testbench

//  Shares the single-port SoC memory between CPU instr fetch (port 0), CPU data (port 1)
//  and VPU XIF memory requests (port 2). Single-cycle req/gnt per port; round-robin arbitration.

---
 rtl/soc_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_soc_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: shares the single-port SoC memory between CPU fetch (port 0),
// CPU data (port 1) and VPU (port 2). Round-robin grant, optional VPU lock with a
// bounded burst length, fixed one-cycle response routed back to the granted port.
// Build option: define SOC_ARB_PERF_EN to build the grant/conflict counters;
// without it perf_cnt_o is tied to zero.
module soc_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] MEM_BYTES = 32'h2000,
  parameter int unsigned MAX_LOCK  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [2:0]              m_req_i,
  input  logic [2:0]              m_we_i,
  input  logic [3*ADDR_W-1:0]     m_addr_i,
  input  logic [3*DATA_W-1:0]     m_wdata_i,
  input  logic [3*(DATA_W/8)-1:0] m_be_i,
  input  logic                    vpu_lock_i,
  output logic [2:0]              m_gnt_o,
  output logic [2:0]              m_rvalid_o,
  output logic [DATA_W-1:0]       m_rdata_o,
  output logic                    m_err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  output logic [DATA_W/8-1:0]     mem_be_o,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  output logic [4*32-1:0]         perf_cnt_o
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned LCW  = $clog2(MAX_LOCK + 1);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  typedef enum logic [1:0] {ARB = 2'd0, LOCK = 2'd1, BACKOFF = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [1:0]     rr_ptr_q, rr_ptr_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [2:0]     rvalid_q, rvalid_d;
  logic           err_q, err_d;
  logic           rd_q, rd_d;

  logic [ADDR_W-1:0] addr_p  [3];
  logic [DATA_W-1:0] wdata_p [3];
  logic [BE_W-1:0]   be_p    [3];

  logic [2:0] elig;
  logic [2:0] cand;
  logic [2:0] gnt;
  logic [1:0] win;
  logic       win_valid;
  logic       addr_err;

  for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
    assign addr_p[gi]  = m_addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_p[gi] = m_wdata_i[gi*DATA_W +: DATA_W];
    assign be_p[gi]    = m_be_i[gi*BE_W +: BE_W];
  end

  // Pick the first eligible requester scanning upward from the round-robin pointer.
  always_comb begin
    elig = 3'b000;
    case (state_q)
      ARB:     elig = m_req_i;
      LOCK:    elig = m_req_i & 3'b100;
      BACKOFF: elig = m_req_i & 3'b011;
      default: elig = 3'b000;
    endcase
    if (!rst_ni) elig = 3'b000;
    win_valid = 1'b0;
    win       = 2'd0;
    cand      = 3'd0;
    // Walk from farthest to nearest so the nearest eligible port is kept.
    for (int k = 2; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (elig[cand[1:0]]) begin
        win_valid = 1'b1;
        win       = cand[1:0];
      end
    end
    gnt      = win_valid ? (3'b001 << win) : 3'b000;
    addr_err = win_valid && (addr_p[win] >= MEM_LIMIT);
  end

  assign m_gnt_o     = gnt;
  assign mem_req_o   = win_valid & ~addr_err;
  assign mem_we_o    = win_valid & m_we_i[win];
  assign mem_addr_o  = win_valid ? addr_p[win]  : '0;
  assign mem_wdata_o = win_valid ? wdata_p[win] : '0;
  assign mem_be_o    = win_valid ? be_p[win]    : '0;

  // Next-state for arbitration mode, round-robin pointer, lock burst length and response pipe.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    rvalid_d   = gnt;
    err_d      = addr_err;
    rd_d       = win_valid & ~m_we_i[win] & ~addr_err;
    case (state_q)
      ARB: begin
        if (win_valid) begin
          rr_ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
          if (win == 2'd2 && vpu_lock_i) begin
            lock_cnt_d = LCW'(1);
            state_d    = (lock_cnt_d == LCW'(MAX_LOCK)) ? BACKOFF : LOCK;
          end
        end
      end
      LOCK: begin
        if (win_valid) begin
          rr_ptr_d   = 2'd0;
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
        if (!vpu_lock_i) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else if (win_valid && lock_cnt_d == LCW'(MAX_LOCK)) begin
          state_d = BACKOFF;
        end
      end
      BACKOFF: begin
        state_d    = ARB;
        lock_cnt_d = '0;
        rr_ptr_d   = 2'd0;
      end
      default: begin
        state_d    = ARB;
        lock_cnt_d = '0;
        rr_ptr_d   = 2'd0;
      end
    endcase
  end

  // State register; reset abandons any lock and drops the pending response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      rr_ptr_q   <= 2'd0;
      lock_cnt_q <= '0;
      rvalid_q   <= 3'b000;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
    end
  end

  assign m_rvalid_o = rst_ni ? rvalid_q : 3'b000;
  assign m_err_o    = rst_ni & err_q;
  assign m_rdata_o  = (rst_ni && rd_q) ? mem_rdata_i : '0;

`ifdef SOC_ARB_PERF_EN
  logic [3:0][31:0] cnt_q, cnt_d;
  logic             conflict;

  assign conflict = (m_req_i[0] & m_req_i[1]) | (m_req_i[0] & m_req_i[2]) |
                    (m_req_i[1] & m_req_i[2]);

  // Free-running wrapping counters: one per port grant plus multi-request cycles.
  always_comb begin
    cnt_d    = cnt_q;
    cnt_d[0] = cnt_q[0] + {31'd0, gnt[0]};
    cnt_d[1] = cnt_q[1] + {31'd0, gnt[1]};
    cnt_d[2] = cnt_q[2] + {31'd0, gnt[2]};
    cnt_d[3] = cnt_q[3] + {31'd0, conflict};
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign perf_cnt_o = cnt_q;
`else
  assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Testbench for soc_mem_arbiter: directed stimulus, a behavioural arbitration model
// checked every cycle, and literal expectations for the documented scenarios.
module tb_soc_mem_arbiter;

  localparam int unsigned MAX_LOCK = 16;
  localparam logic [31:0] MEM_BYTES = 32'h2000;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [2:0]    m_req_i, m_we_i;
  logic [95:0]   m_addr_i, m_wdata_i;
  logic [11:0]   m_be_i;
  logic          vpu_lock_i;
  logic [2:0]    m_gnt_o, m_rvalid_o;
  logic [31:0]   m_rdata_o;
  logic          m_err_o, mem_req_o, mem_we_o;
  logic [31:0]   mem_addr_o, mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_rdata_i = 32'd0;
  logic [127:0]  perf_cnt_o;

  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];

  assign m_addr_i  = {addr[2], addr[1], addr[0]};
  assign m_wdata_i = {wdata[2], wdata[1], wdata[0]};
  assign m_be_i    = {be[2], be[1], be[0]};

  always #5 clk_i = ~clk_i;

  soc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(MEM_BYTES), .MAX_LOCK(MAX_LOCK)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .m_req_i(m_req_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_be_i(m_be_i), .vpu_lock_i(vpu_lock_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
    .perf_cnt_o(perf_cnt_o)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Memory behind the arbiter: 2048 words, one-cycle read latency, byte-enabled writes.
  logic [31:0] mem [2048];
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] <= 32'hA500_0000 + 32'(i);
    mem[4] <= 32'hDEADBEEF;
  end
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_addr_o[12:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= mem[mem_addr_o[12:2]];
      end
    end
  end

  // Behavioural model: who gets the memory this cycle and what answer comes back next cycle.
  int          pref = 0;     // port offered first
  int          mode = 0;     // 0 open to all, 1 VPU-owned burst, 2 one-cycle cool-down
  int          run_len = 0;  // VPU grants in the current owned burst
  logic [2:0]  pend_valid = 3'b000;
  logic        pend_err = 1'b0;
  logic [31:0] pend_data = 32'd0;
  int unsigned n_gnt [3] = '{0, 0, 0};
  int unsigned n_conf = 0;

  always @(negedge clk_i) begin : cmp
    int w;
    int p;
    logic bad_addr;
    logic [2:0] exp_gnt;
`ifdef SOC_ARB_PERF_EN
    chk("perf", perf_cnt_o, {n_conf, n_gnt[2], n_gnt[1], n_gnt[0]});
`else
    chk("perf", perf_cnt_o, 128'd0);
`endif
    chk("rvalid", m_rvalid_o, rst_ni ? pend_valid : 3'b000);
    chk("err", m_err_o, rst_ni && pend_valid != 3'b000 && pend_err);
    if (rst_ni && pend_valid != 3'b000) chk("rdata", m_rdata_o, pend_data);

    w = -1;
    if (rst_ni) begin
      for (int k = 0; k < 3; k++) begin
        p = (pref + k) % 3;
        if (w < 0 && m_req_i[p] && (mode == 0 || (mode == 1 && p == 2) || (mode == 2 && p != 2)))
          w = p;
      end
    end
    exp_gnt  = (w < 0) ? 3'b000 : 3'(1 << w);
    bad_addr = (w >= 0) && (addr[w] >= MEM_BYTES);
    chk("gnt", m_gnt_o, exp_gnt);
    chk("mem_req", mem_req_o, (w >= 0) && !bad_addr);
    if (w >= 0) begin
      chk("mem_we", mem_we_o, m_we_i[w]);
      chk("mem_addr", mem_addr_o, addr[w]);
      chk("mem_wdata", mem_wdata_o, wdata[w]);
      chk("mem_be", mem_be_o, be[w]);
    end

    if (!rst_ni) begin
      pref = 0; mode = 0; run_len = 0;
      pend_valid = 3'b000; pend_err = 1'b0; pend_data = 32'd0;
      n_gnt = '{0, 0, 0}; n_conf = 0;
    end else begin
      if ((int'(m_req_i[0]) + int'(m_req_i[1]) + int'(m_req_i[2])) >= 2) n_conf++;
      pend_valid = exp_gnt;
      pend_err   = bad_addr;
      pend_data  = (w >= 0 && !m_we_i[w] && !bad_addr) ? mem[addr[w][12:2]] : 32'd0;
      if (w >= 0) n_gnt[w]++;
      case (mode)
        0: if (w >= 0) begin
             pref = (w + 1) % 3;
             if (w == 2 && vpu_lock_i) begin
               run_len = 1;
               mode = (run_len >= MAX_LOCK) ? 2 : 1;
             end
           end
        1: begin
             if (w == 2) begin run_len++; pref = 0; end
             if (!vpu_lock_i) begin mode = 0; run_len = 0; end
             else if (run_len >= MAX_LOCK) mode = 2;
           end
        default: begin mode = 0; pref = 0; run_len = 0; end
      endcase
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  logic [2:0] exp3 [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [2:0] exp_lr [4] = '{3'b100, 3'b100, 3'b100, 3'b001};

  initial begin
    int run;
    int max_run;
    logic [2:0] e4;
    rst_ni = 1'b0; m_req_i = 3'b111; m_we_i = 3'b000; vpu_lock_i = 1'b0;
    addr  = '{32'h0, 32'h4, 32'h8};
    wdata = '{32'h0, 32'h0, 32'h0};
    be    = '{4'hF, 4'hF, 4'hF};

    // T1: reset held with everyone requesting
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t1_gnt", m_gnt_o, 3'b000);
      chk("t1_mem_req", mem_req_o, 1'b0);
      chk("t1_rvalid", m_rvalid_o, 3'b000);
      next_cycle();
    end

    // T3: round-robin with all three held
    rst_ni = 1'b1;
    for (int k = 0; k < 6; k++) begin
      at_neg();
      chk("t3_gnt", m_gnt_o, exp3[k]);
      if (k > 0) chk("t3_rvalid", m_rvalid_o, exp3[k-1]);
      next_cycle();
    end
    m_req_i = 3'b000;
    at_neg();
    chk("t3_last_rvalid", m_rvalid_o, 3'b100);
    chk("t3_last_rdata", m_rdata_o, 32'hA500_0002);
    // T6: counters after the round-robin run
`ifdef SOC_ARB_PERF_EN
    chk("t6_gnt0", perf_cnt_o[31:0], 32'd2);
    chk("t6_gnt1", perf_cnt_o[63:32], 32'd2);
    chk("t6_gnt2", perf_cnt_o[95:64], 32'd2);
    chk("t6_conflict", perf_cnt_o[127:96], 32'd6);
`else
    chk("t6_perf_off", perf_cnt_o, 128'd0);
`endif
    next_cycle();

    // T2: single read from port 1
    m_req_i = 3'b010; addr[1] = 32'h10;
    at_neg();
    chk("t2_gnt", m_gnt_o, 3'b010);
    chk("t2_mem_addr", mem_addr_o, 32'h10);
    next_cycle();
    // partial write from port 1 while the read answers
    m_we_i = 3'b010; addr[1] = 32'h20; wdata[1] = 32'h1122_3344; be[1] = 4'b0101;
    at_neg();
    chk("t2_rvalid", m_rvalid_o, 3'b010);
    chk("t2_rdata", m_rdata_o, 32'hDEADBEEF);
    chk("t2_err", m_err_o, 1'b0);
    chk("wr_gnt", m_gnt_o, 3'b010);
    chk("wr_mem_we", mem_we_o, 1'b1);
    next_cycle();
    // read back the written word from port 0
    m_req_i = 3'b001; m_we_i = 3'b000; be[1] = 4'hF; addr[0] = 32'h20;
    at_neg();
    chk("wr_rvalid", m_rvalid_o, 3'b010);
    chk("wr_rdata", m_rdata_o, 32'h0);
    chk("rb_gnt", m_gnt_o, 3'b001);
    next_cycle();
    // T5: out-of-range read from port 0
    addr[0] = 32'h2000;
    at_neg();
    chk("rb_rdata", m_rdata_o, 32'hA522_0044);
    chk("t5_gnt", m_gnt_o, 3'b001);
    chk("t5_mem_req", mem_req_o, 1'b0);
    next_cycle();
    m_req_i = 3'b000; addr[0] = 32'h0;
    at_neg();
    chk("t5_rvalid", m_rvalid_o, 3'b001);
    chk("t5_err", m_err_o, 1'b1);
    chk("t5_rdata", m_rdata_o, 32'h0);
    next_cycle();

    // T4: locked VPU burst with every port requesting (pointer sits at port 1)
    m_req_i = 3'b111; vpu_lock_i = 1'b1;
    run = 0; max_run = 0;
    for (int k = 0; k < 20; k++) begin
      at_neg();
      if (k == 0) e4 = 3'b010;
      else if (k <= 16) e4 = 3'b100;
      else if (k <= 18) e4 = 3'b001;
      else e4 = 3'b010;
      chk("t4_gnt", m_gnt_o, e4);
      if (m_gnt_o == 3'b100) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      next_cycle();
    end
    chk("t4_lock_run", 32'(max_run), 32'd16);
    m_req_i = 3'b000; vpu_lock_i = 1'b0;
    next_cycle();

    // Lock released while port 0 waits
    m_req_i = 3'b101;
    for (int k = 0; k < 4; k++) begin
      vpu_lock_i = (k < 2);
      at_neg();
      chk("rel_gnt", m_gnt_o, exp_lr[k]);
      next_cycle();
    end
    m_req_i = 3'b000; vpu_lock_i = 1'b0;
    next_cycle();

    // Reset in the middle of a lock with a response in flight
    m_req_i = 3'b100; vpu_lock_i = 1'b1;
    at_neg();
    chk("mr_gnt", m_gnt_o, 3'b100);
    next_cycle();
    rst_ni = 1'b0;
    at_neg();
    chk("mr_rst_gnt", m_gnt_o, 3'b000);
    chk("mr_rst_rvalid", m_rvalid_o, 3'b000);
    next_cycle();
    rst_ni = 1'b1; m_req_i = 3'b001;
    at_neg();
    chk("mr_after_gnt", m_gnt_o, 3'b001);
    next_cycle();
    m_req_i = 3'b000; vpu_lock_i = 1'b0;
    at_neg();
    chk("mr_after_rvalid", m_rvalid_o, 3'b001);
    chk("mr_after_rdata", m_rdata_o, 32'hA500_0000);
    next_cycle();
    next_cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
